// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - state encoding and counter sizing shared by the shift frame controller
package shift_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // The unused code point behaves as IDLE so a corrupted state recovers on its own
   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_DONE  = ST_DONE,
      S_SPARE = 2'd3
   } state_t;

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_reg_piso.sv
// rtl/shift_reg_piso.sv - parallel-load, serial-out shift register, MSB first
module shift_reg_piso #(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Load,
   input  logic             Shift,
   input  logic [WIDTH-1:0] D,
   output logic             Msb
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         q <= '0;
      end else if (Load) begin
         q <= D;
      end else if (Shift) begin
         q <= q << 1;
      end
   end

   assign Msb = q[WIDTH-1];

endmodule

// File: rtl/shift_frame_ctrl.sv
// rtl/shift_frame_ctrl.sv - accepts one word per handshake and serialises it MSB first, DIV cycles per bit
module shift_frame_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV   = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             In_valid,
   input  logic [WIDTH-1:0] In_data,
   output logic             In_ready,
   output logic             Ser_out,
   output logic             Ser_en,
   output logic             Busy,
   output logic             Done
);

   localparam int BW = cnt_width(WIDTH + 1);
   localparam int DW = cnt_width(DIV);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   if (WIDTH < 1 || DIV < 1) begin : g_bad_param
      $error("shift_frame_ctrl: WIDTH and DIV must both be at least 1");
   end

   state_t          state;
   state_t          state_nxt;
   logic [BW-1:0]   bit_cnt;
   logic [DW-1:0]   div_cnt;
   logic            idle_st;
   logic            div_wrap;
   logic            last_bit;
   logic            load;
   logic            msb;

   assign idle_st  = (state == S_IDLE) || (state == S_SPARE);
   assign div_wrap = (state == S_SHIFT) && (div_cnt == DIV_LAST);
   assign last_bit = div_wrap && (bit_cnt == BIT_LAST);
   assign load     = idle_st && In_valid;

   shift_reg_piso #(.WIDTH(WIDTH)) u_piso (
      .Clock (Clock),
      .Reset (Reset),
      .Load  (load),
      .Shift (div_wrap),
      .D     (In_data),
      .Msb   (msb)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // bit_cnt reaches WIDTH on the final shift; it is reloaded before any reuse
   always_ff @(posedge Clock) begin
      if (Reset || load) begin
         bit_cnt <= '0;
         div_cnt <= '0;
      end else if (state == S_SHIFT) begin
         if (div_wrap) begin
            div_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      In_ready  = 1'b0;
      Ser_out   = 1'b0;
      Ser_en    = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      unique case (state)
         S_SHIFT: begin
            Ser_en  = 1'b1;
            Ser_out = msb;
            Busy    = 1'b1;
            if (last_bit) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            Done      = 1'b1;
            Busy      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            In_ready = 1'b1;
            if (In_valid) begin
               state_nxt = S_SHIFT;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// tb/tb_shift_frame_ctrl.sv - scoreboard bench for shift_frame_ctrl over three WIDTH/DIV configurations
module tb_shift_frame_ctrl;

   localparam int NI = 3;

   typedef struct {
      int   c;
      logic b;
   } ev_t;

   logic          clk = 1'b0;
   int            cyc = 0;
   logic [NI-1:0] rst;
   logic [NI-1:0] vld;
   logic [NI-1:0] rdy;
   logic [3:0]    dat [NI];
   logic          mon_en = 1'b0;
   logic          end_chk = 1'b0;
   int            n_cmp_top = 0;
   int            n_err_top = 0;

   always #5 clk = ~clk;

   // cycle c is the interval that ends at rising edge number c
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < NI; gi++) begin : g
      localparam int W = (gi == 2) ? 1 : 4;
      localparam int D = (gi == 0) ? 1 : (gi == 1) ? 3 : 2;

      logic         ser_out, ser_en, busy, done, in_ready;
      ev_t          bitq[$];
      int           doneq[$];
      int           ready_cyc = 0;
      int           n_cmp = 0;
      int           n_err = 0;
      logic [W-1:0] w;
      logic         exp_ready;
      ev_t          ev;

      shift_frame_ctrl #(.WIDTH(W), .DIV(D)) dut (
         .Clock    (clk),
         .Reset    (rst[gi]),
         .In_valid (vld[gi]),
         .In_data  (dat[gi][W-1:0]),
         .In_ready (in_ready),
         .Ser_out  (ser_out),
         .Ser_en   (ser_en),
         .Busy     (busy),
         .Done     (done)
      );

      assign rdy[gi] = in_ready;

      task automatic chk(input string nm, input logic act, input logic exp);
         n_cmp++;
         if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d cycle %0d: got %b expected %b", nm, gi, cyc, act, exp);
         end
      endtask

      task automatic chk_int(input string nm, input int act, input int exp);
         n_cmp++;
         if (act != exp) begin
            n_err++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", nm, gi, cyc, act, exp);
         end
      endtask

      // Reference: a word accepted at edge t puts bit k on the line for cycles
      // t+1+k*D .. t+(k+1)*D, pulses Done in t+W*D+1 and is ready again in t+W*D+2
      always @(posedge clk) begin
         if (rst[gi]) begin
            bitq.delete();
            doneq.delete();
            ready_cyc = cyc + 1;
         end else if (vld[gi] && cyc >= ready_cyc) begin
            w = dat[gi][W-1:0];
            for (int k = 0; k < W; k++)
               for (int d = 0; d < D; d++)
                  bitq.push_back('{cyc + 1 + k * D + d, w[W-1-k]});
            doneq.push_back(cyc + W * D + 1);
            ready_cyc = cyc + W * D + 2;
         end
      end

      always @(negedge clk) begin
         if (mon_en) begin
            exp_ready = (cyc >= ready_cyc);
            chk("in_ready", in_ready, exp_ready);
            chk("busy", busy, !exp_ready);
            if (ser_en) begin
               if (bitq.size() == 0) begin
                  chk("ser_en_unexpected", ser_en, 1'b0);
               end else begin
                  ev = bitq.pop_front();
                  chk_int("bit_cycle", cyc, ev.c);
                  chk("ser_out", ser_out, ev.b);
               end
            end else begin
               chk("ser_out_idle", ser_out, 1'b0);
               if (bitq.size() != 0 && bitq[0].c <= cyc) begin
                  chk("ser_en_missing", ser_en, 1'b1);
                  void'(bitq.pop_front());
               end
            end
            if (done) begin
               if (doneq.size() == 0) begin
                  chk("done_unexpected", done, 1'b0);
               end else begin
                  chk_int("done_cycle", cyc, doneq.pop_front());
               end
            end else if (doneq.size() != 0 && doneq[0] <= cyc) begin
               chk("done_missing", done, 1'b1);
               void'(doneq.pop_front());
            end
         end
         if (end_chk) begin
            chk_int("bits_left", bitq.size(), 0);
            chk_int("dones_left", doneq.size(), 0);
         end
      end
   end

   // Called on a falling edge; returns on the falling edge just after the accepting edge
   task automatic offer(input int idx, input logic [3:0] word, input bit scramble);
      int n;
      n = 0;
      vld[idx] = 1'b1;
      while (!rdy[idx] && n < 200) begin
         dat[idx] = scramble ? 4'($urandom) : word;
         @(negedge clk);
         n++;
      end
      n_cmp_top++;
      if (n >= 200) begin
         n_err_top++;
         $display("FAIL accept_timeout inst%0d: waited %0d cycles, limit 200", idx, n);
      end
      dat[idx] = word;
      @(negedge clk);
   endtask

   task automatic send(input int idx, input logic [3:0] word);
      offer(idx, word, 1'b0);
      vld[idx] = 1'b0;
      dat[idx] = 4'($urandom);
   endtask

   initial begin
      int tot_cmp;
      int tot_err;
      rst = '1;
      vld = '0;
      for (int i = 0; i < NI; i++) dat[i] = '0;
      repeat (3) @(negedge clk);
      rst = '0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      send(0, 4'b1011);
      repeat (8) @(negedge clk);

      send(1, 4'b0110);
      repeat (16) @(negedge clk);

      // Held valid: second word waits for IDLE while In_data churns during frame one
      offer(0, 4'hA, 1'b0);
      offer(0, 4'h5, 1'b1);
      vld[0] = 1'b0;
      repeat (8) @(negedge clk);

      send(0, 4'b1111);
      @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      repeat (8) @(negedge clk);

      rst[0] = 1'b1;
      vld[0] = 1'b1;
      dat[0] = 4'hF;
      @(negedge clk);
      rst[0] = 1'b0;
      vld[0] = 1'b0;
      repeat (3) @(negedge clk);
      send(0, 4'b1001);
      repeat (8) @(negedge clk);

      send(2, 4'b0001);
      repeat (6) @(negedge clk);

      for (int i = 0; i < NI; i++) begin
         for (int r = 0; r < 15; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 2) == 0) begin
               offer(i, 4'($urandom), 1'b1);
            end else begin
               send(i, 4'($urandom));
            end
            vld[i] = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
               repeat ($urandom_range(0, 6)) @(negedge clk);
               rst[i] = 1'b1;
               @(negedge clk);
               rst[i] = 1'b0;
            end
         end
         repeat (16) @(negedge clk);
      end

      repeat (20) @(negedge clk);
      @(posedge clk);
      end_chk = 1'b1;
      @(posedge clk);
      end_chk = 1'b0;
      @(negedge clk);

      tot_cmp = n_cmp_top + g[0].n_cmp + g[1].n_cmp + g[2].n_cmp;
      tot_err = n_err_top + g[0].n_err + g[1].n_err + g[2].n_err;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", tot_cmp, tot_err);
      $finish;
   end

endmodule
